// File: rtl/core_launch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_launch_pkg
// Brief    : Shared state encoding and default sizing for the core launcher.
// Revision : 1.0 - initial release
// ============================================================================
package core_launch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        RUN  = 3'd2,
        FIN  = 3'd3,
        FAIL = 3'd4
    } launch_state_t;

    localparam int c_CW_DEFAULT         = 16;
    localparam int c_RST_CYCLES_DEFAULT = 2;
    localparam int c_TIMEOUT_DEFAULT    = 4096;

endpackage : core_launch_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count,
    output logic         o_at_max
);

    logic [W-1:0] r_count;

    assign o_count  = r_count;
    assign o_at_max = &r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/core_launcher.sv
`default_nettype none
// ============================================================================
// Module   : core_launcher
// Brief    : Resets the core, raises req and waits for done while counting
//            run cycles. Optional run timeout: CORE_LAUNCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module core_launcher
    import core_launch_pkg::*;
#(
    parameter int RST_CYCLES = c_RST_CYCLES_DEFAULT,
    parameter int CW         = c_CW_DEFAULT,
    parameter int TIMEOUT    = c_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycles
);

    localparam int              c_RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RW-1:0] c_RST_LAST = c_RW'(RST_CYCLES - 1);

    generate
        if (RST_CYCLES < 1 || TIMEOUT < 1 || TIMEOUT >= (1 << CW)) begin : g_bad_params
            $error("core_launcher: RST_CYCLES must be >= 1 and 1 <= TIMEOUT < 2**CW");
        end
    endgenerate

    launch_state_t   r_state;
    logic [c_RW-1:0] r_rst_cnt;
    logic            r_core_reset;
    logic            r_core_req;
    logic            r_busy;
    logic            r_finished;
    logic            r_timed_out;

    logic            w_launch;
    logic            w_count_en;
    logic            w_timeout_hit;
    logic [CW-1:0]   w_cycles;
    logic            w_cnt_max;

    assign w_launch   = start && (r_state == IDLE || r_state == FIN || r_state == FAIL);
    assign w_count_en = (r_state == RUN) && !w_cnt_max;

`ifdef CORE_LAUNCH_TIMEOUT_EN
    localparam logic [CW-1:0] c_TO_LAST = CW'(TIMEOUT - 1);
    // The TIMEOUT-th run cycle without done is the last one; cycles ends at TIMEOUT.
    assign w_timeout_hit = (r_state == RUN) && (w_cycles == c_TO_LAST);
`else
    assign w_timeout_hit = 1'b0;
`endif

    sat_counter #(
        .W (CW)
    ) u_cycles (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_launch),
        .i_enable (w_count_en),
        .o_count  (w_cycles),
        .o_at_max (w_cnt_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rst_cnt    <= '0;
            r_core_reset <= 1'b1;
            r_core_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FIN, FAIL: begin
                    if (start) begin
                        r_state      <= RST;
                        r_rst_cnt    <= '0;
                        r_core_reset <= 1'b1;
                        r_core_req   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_finished   <= 1'b0;
                        r_timed_out  <= 1'b0;
                    end
                end
                RST: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_rst_cnt == c_RST_LAST) begin
                        r_state      <= RUN;
                        r_core_reset <= 1'b0;
                        r_core_req   <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Priority: abort, then done, then timeout.
                    if (abort) begin
                        r_state      <= IDLE;
                        r_core_reset <= 1'b1;
                        r_core_req   <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (core_done) begin
                        r_state    <= FIN;
                        r_core_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_state      <= FAIL;
                        r_core_reset <= 1'b1;
                        r_core_req   <= 1'b0;
                        r_busy       <= 1'b0;
                        r_timed_out  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_core_reset <= 1'b1;
                    r_core_req   <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset = r_core_reset;
    assign core_req   = r_core_req;
    assign busy       = r_busy;
    assign finished   = r_finished;
    assign timed_out  = r_timed_out;
    assign cycles     = w_cycles;

endmodule : core_launcher
`default_nettype wire

// File: tb/tb_core_launcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_launcher
// Brief    : Randomized launches of core_launcher checked against a
//            run-outcome reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_launcher;

    localparam int c_RST_CYC = 2;
    localparam int c_CW      = 5;
    localparam int c_TMO     = 20;
    localparam int c_MAXC    = (1 << c_CW) - 1;
`ifdef CORE_LAUNCH_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic            core_done;
    logic            core_reset;
    logic            core_req;
    logic            busy;
    logic            finished;
    logic            timed_out;
    logic [c_CW-1:0] cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_launcher #(
        .RST_CYCLES (c_RST_CYC),
        .CW         (c_CW),
        .TIMEOUT    (c_TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .core_done  (core_done),
        .core_reset (core_reset),
        .core_req   (core_req),
        .busy       (busy),
        .finished   (finished),
        .timed_out  (timed_out),
        .cycles     (cycles)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > c_MAXC) ? c_MAXC : v;
    endfunction

    // Reference: a run ends at the first run cycle c where abort (c==n_abort),
    // else done (c>=n_done), else timeout (c==TIMEOUT, only when enabled).
    task automatic launch(input int n_done, input int n_abort, input bit stale,
                          input bit poke, input bit with_abort);
        int c;
        int kind;
        int exp_cyc;
        start     = 1'b1;
        abort     = with_abort;
        core_done = stale;
        for (int i = 0; i < c_RST_CYC; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            check_eq("rst_core_reset", core_reset, 1);
            check_eq("rst_core_req", core_req, 0);
            check_eq("rst_busy", busy, 1);
            if (i == 0) begin
                check_eq("rst_cycles_clr", cycles, 0);
                check_eq("rst_finished_clr", finished, 0);
                check_eq("rst_timed_out_clr", timed_out, 0);
            end
        end
        c    = 0;
        kind = 0;
        while (kind == 0) begin
            @(negedge clk);
            c++;
            check_eq("run_core_req", core_req, 1);
            check_eq("run_core_reset", core_reset, 0);
            check_eq("run_busy", busy, 1);
            check_eq("run_cycles", cycles, sat(c - 1));
            core_done = (c >= n_done);
            abort     = (c == n_abort);
            start     = poke && (c == 2);
            if (c == n_abort)                 kind = 1;
            else if (c >= n_done)             kind = 2;
            else if (c_TO_EN && c == c_TMO)   kind = 3;
        end
        @(negedge clk);
        abort   = 1'b0;
        start   = 1'b0;
        exp_cyc = (kind == 3) ? c_TMO : sat(c);
        check_eq("end_cycles", cycles, exp_cyc);
        check_eq("end_busy", busy, 0);
        check_eq("end_core_req", core_req, 0);
        check_eq("end_core_reset", core_reset, (kind == 2) ? 0 : 1);
        check_eq("end_finished", finished, (kind == 2) ? 1 : 0);
        check_eq("end_timed_out", timed_out, (kind == 3) ? 1 : 0);
        @(negedge clk);
        check_eq("hold_finished", finished, (kind == 2) ? 1 : 0);
        check_eq("hold_busy", busy, 0);
        check_eq("hold_cycles", cycles, exp_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        abort     = 1'b0;
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_val_core_reset", core_reset, 1);
        check_eq("rst_val_core_req", core_req, 0);
        check_eq("rst_val_busy", busy, 0);
        check_eq("rst_val_finished", finished, 0);
        check_eq("rst_val_timed_out", timed_out, 0);
        check_eq("rst_val_cycles", cycles, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("idle_after_reset_busy", busy, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("idle_abort_busy", busy, 0);
        check_eq("idle_abort_core_reset", core_reset, 1);

        launch(10, 0, 1'b0, 1'b0, 1'b0);   // normal run
        launch(1, 0, 1'b1, 1'b0, 1'b0);    // stale done through RST
        launch(30, 5, 1'b0, 1'b0, 1'b0);   // abort mid-run
        launch(40, 0, 1'b0, 1'b0, 1'b0);   // timeout or saturation
        launch(8, 0, 1'b0, 1'b1, 1'b0);    // start while busy
        launch(6, 6, 1'b0, 1'b0, 1'b1);    // abort beats done; start beats abort

        for (int k = 0; k < 25; k++) begin
            int nd;
            int na;
            nd = $urandom_range(1, 40);
            na = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
            launch(nd, na, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_core_launcher
`default_nettype wire
